// File: rtl/mem_arbiter.sv
// Two-requester (CPU/DMA) round-robin arbiter for a single shared memory port.
// Each transaction: one IDLE sample cycle, MEM_LAT strobe cycles, one ready cycle.
module mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ready,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_ready,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_read,
  output logic          mem_write,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    grant,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  localparam logic [3:0] CNT_LOAD = 4'(MEM_LAT - 1);

  // Handshake: a requester raises req and holds it until its one-cycle ready;
  // req is looked at only in IDLE, and rdata is valid in the ready cycle.
  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          owner_q, owner_d;  // 0 = CPU, 1 = DMA
  logic          last_q, last_d;    // requester granted most recently
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] dma_rdata_q, dma_rdata_d;

  logic any_req;
  logic win_dma;

  assign any_req = cpu_req | dma_req;
  // On a tie the requester that was not served last wins.
  assign win_dma = dma_req & (~cpu_req | ~last_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    last_d      = last_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          state_d = S_ACCESS;
          cnt_d   = CNT_LOAD;
          owner_d = win_dma;
          last_d  = win_dma;
          we_d    = win_dma ? dma_we    : cpu_we;
          addr_d  = win_dma ? dma_addr  : cpu_addr;
          wdata_d = win_dma ? dma_wdata : cpu_wdata;
        end
      end
      S_ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = S_DONE;
          if (!we_q) begin
            if (owner_q) dma_rdata_d = mem_rdata;
            else         cpu_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    grant     = 2'b00;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    cpu_ready = 1'b0;
    dma_ready = 1'b0;
    case (state_q)
      S_ACCESS: begin
        grant     = owner_q ? 2'b10 : 2'b01;
        mem_read  = ~we_q;
        mem_write = we_q;
        mem_addr  = addr_q;
        mem_wdata = we_q ? wdata_q : '0;
      end
      S_DONE: begin
        grant     = owner_q ? 2'b10 : 2'b01;
        cpu_ready = ~owner_q;
        dma_ready = owner_q;
      end
      default: ;
    endcase
  end

  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic against a
// transaction-timeline model; a second instance runs with a one-cycle memory.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int L  = 2;
  localparam int W  = DW + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we, dma_req, dma_we;
  logic [AW-1:0] cpu_addr, dma_addr;
  logic [DW-1:0] cpu_wdata, dma_wdata, mem_rdata;
  logic [DW-1:0] cpu_rdata, dma_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic          cpu_ready, dma_ready, mem_read, mem_write;
  logic [1:0]    grant, dbg_state;
  logic [DW-1:0] l1_cpu_rdata, l1_dma_rdata, l1_mem_wdata;
  logic [AW-1:0] l1_mem_addr;
  logic          l1_cpu_ready, l1_dma_ready, l1_mem_read, l1_mem_write;
  logic [1:0]    l1_grant, l1_dbg_state;

  // ---------------- clock / DUTs ----------------
  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(L)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ready(dma_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_rdata(mem_rdata), .grant(grant), .dbg_state(dbg_state)
  );

  mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(1)) u_lat1 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(l1_cpu_rdata), .cpu_ready(l1_cpu_ready),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(l1_dma_rdata), .dma_ready(l1_dma_ready),
    .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata), .mem_read(l1_mem_read),
    .mem_write(l1_mem_write), .mem_rdata(mem_rdata), .grant(l1_grant),
    .dbg_state(l1_dbg_state)
  );

  // ---------------- reference model / scoreboard ----------------
  int            n_vec = 0;
  int            n_err = 0;
  int            cyc   = 0;
  bit            m_busy, m_owner, m_we, m_last;
  int            m_start;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_crd, m_drd;
  logic [W-1:0]  exp_q[$];
  int            order_q[$];
  int            when_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy  = 1'b0;
    m_last  = 1'b1;
    m_start = 0;
    m_crd   = '0;
    m_drd   = '0;
    exp_q.delete();
  endtask

  task automatic check_outputs();
    int k;
    bit acc, done;
    logic [W-1:0] e;
    k    = cyc - m_start;
    acc  = m_busy && k >= 1 && k <= L;
    done = m_busy && k == L + 1;
    chk("grant", grant, (acc || done) ? (m_owner ? 2 : 1) : 0);
    chk("mem_read", mem_read, acc && !m_we);
    chk("mem_write", mem_write, acc && m_we);
    chk("mem_addr", mem_addr, acc ? m_addr : '0);
    chk("mem_wdata", mem_wdata, (acc && m_we) ? m_wdata : '0);
    chk("cpu_ready", cpu_ready, done && !m_owner);
    chk("dma_ready", dma_ready, done && m_owner);
    chk("cpu_rdata", cpu_rdata, m_crd);
    chk("dma_rdata", dma_rdata, m_drd);
    if (cpu_ready === 1'b1 || dma_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_ready", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_owner", dma_ready, e[DW]);
        chk("sb_rdata", dma_ready ? dma_rdata : cpu_rdata, e[DW-1:0]);
      end
    end
  endtask

  // Advance the model across the coming rising edge, then check the new cycle.
  task automatic cycle();
    int k;
    if (reset) begin
      if (!m_busy) begin
        if (cpu_req || dma_req) begin
          m_owner = (cpu_req && dma_req) ? ~m_last : dma_req;
          m_last  = m_owner;
          m_busy  = 1'b1;
          m_start = cyc;
          m_we    = m_owner ? dma_we    : cpu_we;
          m_addr  = m_owner ? dma_addr  : cpu_addr;
          m_wdata = m_owner ? dma_wdata : cpu_wdata;
        end
      end else begin
        k = cyc - m_start;
        if (k == L) begin
          if (!m_we) begin
            if (m_owner) m_drd = mem_rdata;
            else         m_crd = mem_rdata;
          end
          exp_q.push_back({m_owner, m_owner ? m_drd : m_crd});
        end
        if (k == L + 1) m_busy = 1'b0;
      end
    end
    @(negedge clk);
    cyc++;
    check_outputs();
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
    mem_rdata = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1'b0;
    #1;
    model_reset();
    check_outputs();
    cycle();
    cycle();
    reset = 1'b1;
  endtask

  task automatic drain();
    cpu_req = 0;
    dma_req = 0;
    repeat (L + 3) cycle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int nw, nr;
    logic [DW-1:0] drd_before;
    reset = 1'b0;
    idle_inputs();

    // Reset state and single CPU read (also checks the MEM_LAT=1 instance)
    apply_reset();
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_grant", grant, 0);
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10; mem_rdata = 32'hAABBCCDD;
    cycle();
    chk("rd_grant_k1", grant, 2'b01);
    chk("rd_addr_k1", mem_addr, 32'h10);
    chk("l1_read_k1", l1_mem_read, 1);
    chk("l1_rdy_k1", l1_cpu_ready, 0);
    cycle();
    chk("rd_read_k2", mem_read, 1);
    chk("l1_read_k2", l1_mem_read, 0);
    chk("l1_rdy_k2", l1_cpu_ready, 1);
    chk("l1_rdata_k2", l1_cpu_rdata, 32'hAABBCCDD);
    cycle();
    chk("rd_rdy_t3", cpu_ready, 1);
    chk("rd_rdata_t3", cpu_rdata, 32'hAABBCCDD);
    chk("rd_read_t3", mem_read, 0);
    cpu_req = 0;
    drain();

    // Both requesting from reset release: strict alternation, CPU first
    apply_reset();
    cpu_req = 1; dma_req = 1; cpu_addr = 32'h100; dma_addr = 32'h200;
    order_q.delete();
    when_q.delete();
    for (int i = 0; i < 40 && order_q.size() < 4; i++) begin
      mem_rdata = $urandom;
      cycle();
      if (cpu_ready) begin order_q.push_back(0); when_q.push_back(cyc); end
      if (dma_ready) begin order_q.push_back(1); when_q.push_back(cyc); end
    end
    chk("rr_count", order_q.size(), 4);
    for (int i = 0; i < order_q.size(); i++) begin
      chk("rr_order", order_q[i], i % 2);
      if (i > 0) chk("rr_gap", when_q[i] - when_q[i-1], L + 2);
    end
    drain();

    // DMA write with CPU/DMA inputs wandering mid-transaction
    drd_before = m_drd;
    dma_req = 1; dma_we = 1; dma_addr = 32'h40; dma_wdata = 32'h12345678;
    cycle();
    nw = 0; nr = 0;
    for (int i = 0; i < L + 2; i++) begin
      if (mem_write && mem_addr == 32'h40 && mem_wdata == 32'h12345678) nw++;
      if (dma_ready) begin nr++; dma_req = 0; end
      cpu_addr = $urandom; dma_addr = $urandom; dma_wdata = $urandom;
      cycle();
    end
    chk("wr_cycles", nw, L);
    chk("wr_ready_pulses", nr, 1);
    chk("wr_rdata_kept", dma_rdata, drd_before);
    drain();

    // Reset in the second ACCESS cycle of a CPU read
    apply_reset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h80; mem_rdata = 32'h5555AAAA;
    cycle();
    cycle();
    chk("abort_pre_read", mem_read, 1);
    reset = 1'b0;
    #1;
    model_reset();
    check_outputs();
    chk("abort_read_drop", mem_read, 0);
    chk("abort_grant", grant, 0);
    cycle();
    cycle();
    reset = 1'b1;
    dma_req = 1;
    cycle();
    chk("abort_first_grant", grant, 2'b01);
    drain();

    // DMA drops its request during ACCESS; transaction still completes
    dma_req = 1; dma_we = 0; dma_addr = 32'h44; mem_rdata = 32'hCAFEF00D;
    cycle();
    dma_req = 0;
    nr = 0;
    for (int i = 0; i < L + 3; i++) begin
      cycle();
      if (dma_ready) nr++;
    end
    chk("drop_ready_once", nr, 1);
    chk("drop_idle_grant", grant, 0);
    chk("drop_rdata", dma_rdata, 32'hCAFEF00D);

    // Randomized traffic, including occasional mid-stream resets
    for (int i = 0; i < 1500; i++) begin
      cpu_req   = ($urandom_range(0, 3) != 0);
      dma_req   = ($urandom_range(0, 2) != 0);
      cpu_we    = $urandom_range(0, 1);
      dma_we    = $urandom_range(0, 1);
      cpu_addr  = $urandom;
      dma_addr  = $urandom;
      cpu_wdata = $urandom;
      dma_wdata = $urandom;
      mem_rdata = $urandom;
      if ($urandom_range(0, 199) == 0) begin
        reset = 1'b0;
        #1;
        model_reset();
        check_outputs();
        cycle();
        reset = 1'b1;
      end else begin
        cycle();
      end
    end
    drain();
    chk("sb_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter AW, default 32, address width.
REQ-002 The block SHALL have parameter DW, default 32, data width.
REQ-003 The block SHALL have parameter MEM_LAT, default 2, memory access cycles per transaction; legal range 1..15.
REQ-004 The block SHALL have these ports:
 clk  in  1  single clock, all state on rising edge
 reset  in  1  asynchronous, active-low reset
 cpu_req  in  1  CPU access request, held until cpu_ready
 cpu_we  in  1  CPU write (1) / read (0)
 cpu_addr  in  AW  CPU address
 cpu_wdata  in  DW  CPU write data
 cpu_rdata  out  DW  CPU read data, valid with cpu_ready
 cpu_ready  out  1  one-cycle completion pulse to CPU
 dma_req  in  1  DMA/loader access request, held until dma_ready
 dma_we  in  1  DMA write / read
 dma_addr  in  AW  DMA address
 dma_wdata  in  DW  DMA write data
 dma_rdata  out  DW  DMA read data, valid with dma_ready
 dma_ready  out  1  one-cycle completion pulse to DMA
 mem_addr  out  AW  shared memory address
 mem_wdata  out  DW  shared memory write data
 mem_read  out  1  memory read strobe
 mem_write  out  1  memory write strobe
 mem_rdata  in  DW  memory read data
 grant  out  2  one-hot owner: [0]=CPU, [1]=DMA, 00=idle

Function
REQ-005 The FSM SHALL have states IDLE, ACCESS, DONE; IDLE->ACCESS when any req=1, ACCESS->DONE after MEM_LAT cycles, DONE->IDLE unconditionally.
REQ-006 Requests SHALL be sampled only in IDLE; the winner's we/addr/wdata SHALL be latched on the IDLE->ACCESS edge and held for the whole transaction regardless of later input changes.
REQ-007 Arbitration SHALL be round-robin: a single requester wins; on simultaneous requests the requester not served last wins; a last-served flag SHALL update on each grant.
REQ-008 grant SHALL be one-hot for the owner during ACCESS and DONE, and 00 in IDLE.
REQ-009 During ACCESS, mem_read=~we_latched and mem_write=we_latched for exactly MEM_LAT consecutive cycles, driven by a down-counter loaded with MEM_LAT-1.
REQ-010 mem_addr SHALL equal the latched address during ACCESS and 0 otherwise; mem_wdata SHALL equal latched wdata during write ACCESS and 0 otherwise.
REQ-011 On the last ACCESS cycle of a read, mem_rdata SHALL be captured into the owner's rdata register; the other requester's rdata and any rdata on write SHALL be unchanged.
REQ-012 In DONE, the owner's ready SHALL be 1 for exactly one cycle; the other ready SHALL stay 0.
REQ-013 Latency: req sampled in IDLE at cycle t -> strobes in cycles t+1..t+MEM_LAT -> ready in cycle t+MEM_LAT+1; minimum transaction period MEM_LAT+2 cycles.
REQ-014 A req still high in the cycle after ready (IDLE) SHALL be treated as a new request.
REQ-015 With both requesters continuously asserting, grants SHALL strictly alternate; no requester waits longer than one foreign transaction.
REQ-016 A req deasserted before its ready (protocol violation) SHALL NOT abort an already granted transaction.

Reset
REQ-017 reset=0 SHALL immediately force state IDLE, counter 0, grant 00, all strobes/ready 0, mem_addr/mem_wdata 0, cpu_rdata/dma_rdata 0, last-served=DMA (CPU wins first tie).
REQ-018 Reset asserted mid-transaction SHALL abort it with no ready pulse and no further strobes; after release the next grant follows REQ-017 defaults.

Verification (MEM_LAT=2)
REQ-019 Scenario: reset release, cpu_req=1 read addr 0x10, mem_rdata=0xAABBCCDD -> grant=01, mem_read high 2 cycles, cpu_ready pulse cycle t+3 with cpu_rdata=0xAABBCCDD.
REQ-020 Scenario: cpu_req and dma_req both 1 from reset release -> order CPU, DMA, CPU, DMA; each ready pulse 4 cycles apart.
REQ-021 Scenario: dma_req write addr 0x40 data 0x12345678, cpu_addr changes mid-ACCESS -> mem_write 2 cycles at 0x40/0x12345678, dma_rdata unchanged, dma_ready one pulse.
REQ-022 Scenario: reset asserted in second ACCESS cycle of CPU read -> strobes drop asynchronously, no cpu_ready, grant=00; after release with both req=1, CPU granted first.
REQ-023 Scenario: MEM_LAT=1, CPU single read -> mem_read exactly 1 cycle, cpu_ready in cycle t+2.
REQ-024 Scenario: dma_req deasserted during ACCESS -> transaction completes, dma_ready pulses once, next IDLE grants nothing if cpu_req=0.
